keccak_arb_sched: RTL

- Message-granular round-robin arbiter and sequencer that shares one SHA3-512 keccak core between two 32-bit word-stream requesters (requester 0 = CPU, requester 1 = DMA).
- Per granted message it:
  - pulses the core reset;
  - streams the requester's words into the core with backpressure;
  - waits for the digest;
  - reads the 16 digest words back through the core's hash_num word select and returns them tagged with the requester id.
- Sits between or1200_cpu_tmp's requesters and the keccak core.

---
 rtl/keccak_arb_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/keccak_arb_sched.sv
// Message-granular round-robin arbiter that shares one SHA3-512 keccak core between
// two 32-bit word-stream requesters. It clears the core, feeds the message and reads back the digest.
module keccak_arb_sched #(
  parameter int DIG_WORDS = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic        core_rst,
  output logic        core_en,
  output logic [31:0] core_data,
  output logic        core_is_last,
  input  logic        core_busy,
  input  logic        core_out_ready,
  output logic [4:0]  core_hash_num,
  input  logic [31:0] core_dataout,
  output logic        dig_valid,
  output logic [31:0] dig_data,
  output logic [4:0]  dig_idx,
  output logic        dig_id,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]    IDX_LAST = 5'(DIG_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  // Handshake: a requester word moves only on a cycle where req_valid[i] & req_ready[i];
  // ready is offered to the granted requester in FEED whenever the core is not busy,
  // and never depends on the requester's own valid.
  state_t        state;
  logic          grant;
  logic          rr_ptr;
  logic [CW-1:0] tmo_cnt;

  logic          g_valid;
  logic          g_last;
  logic [31:0]   g_data;
  logic          feed_open;

  always_comb begin
    g_valid      = grant ? req_valid[1] : req_valid[0];
    g_last       = grant ? req_last[1]  : req_last[0];
    g_data       = grant ? req_data1    : req_data0;
    feed_open    = (state == S_FEED) && !core_busy;
    req_ready    = 2'b00;
    if (feed_open) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
    core_en      = feed_open && g_valid;
    core_is_last = core_en && g_last;
    // Hold the data bus at zero outside FEED so nothing leaks out while idle or in reset.
    core_data    = (state == S_FEED) ? g_data : 32'd0;
    core_rst     = (state == S_CLR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      grant         <= 1'b0;
      rr_ptr        <= 1'b0;
      tmo_cnt       <= '0;
      core_hash_num <= 5'd0;
      dig_valid     <= 1'b0;
      dig_data      <= 32'd0;
      dig_idx       <= 5'd0;
      dig_id        <= 1'b0;
      err           <= 1'b0;
    end else begin
      dig_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            grant <= req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
            state <= S_CLR;
          end
        end
        S_CLR: begin
          state <= S_FEED;
        end
        S_FEED: begin
          if (core_is_last) begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A digest arriving on the final allowed cycle still wins over the abort.
          if (core_out_ready) begin
            core_hash_num <= 5'd0;
            state         <= S_READ;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            err     <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_READ: begin
          dig_valid <= 1'b1;
          dig_data  <= core_dataout;
          dig_idx   <= core_hash_num;
          dig_id    <= grant;
          if (core_hash_num == IDX_LAST) begin
            state <= S_DONE;
          end else begin
            core_hash_num <= core_hash_num + 5'd1;
          end
        end
        S_DONE: begin
          rr_ptr <= ~grant;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
